boreal_sram_arbiter: RTL and testbench

- Responder end of the Boreal SRAM word-port protocol (sel/wr/addr/wdata → rdata/ack).
- Owns one single-port SRAM array and serves two initiators: port A (CPU data path) and port B (DMA ring engine).
- Arbitrates between them round-robin, inserts programmable wait states, and returns one single-cycle ack per accepted request.
- Sits between the CPU/DMA masters and the on-chip SRAM macro.

---
 rtl/boreal_pkg.sv | 17 +
 rtl/boreal_sram_arbiter_if.sv | 38 +++
 rtl/boreal_sram_core.sv | 22 ++
 rtl/boreal_sram_arbiter.sv | 133 +++++++++++++
 tb/tb_boreal_sram_arbiter.sv | 275 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/boreal_pkg.sv
// Shared types and constants for the Boreal SRAM word-port responder.
// Holds the arbiter state encoding, the port ids and the default array geometry.
package boreal_pkg;

  typedef enum logic [1:0] {
    SA_IDLE   = 2'd0,
    SA_ACCESS = 2'd1,
    SA_ACK    = 2'd2
  } boreal_state_e;

  localparam logic PORT_A = 1'b0;
  localparam logic PORT_B = 1'b1;

  localparam int BOREAL_SRAM_DEPTH = 1024;
  localparam int BOREAL_SRAM_AW    = 10;

endpackage

// File: rtl/boreal_sram_arbiter_if.sv
// Two-initiator Boreal SRAM word-port bundle (port A = CPU, port B = DMA).
// Handshake: the initiator raises sel with wr/addr/wdata stable and holds them until
// ack; ack is a one-cycle pulse, rdata is valid in that cycle, and sel drops on the
// edge that ends the ack cycle. Dropping sel before ack abandons the request.
interface boreal_sram_arbiter_if #(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 32
);

  logic              a_sel;
  logic              a_wr;
  logic [ADDR_W-1:0] a_addr;
  logic [DATA_W-1:0] a_wdata;
  logic [DATA_W-1:0] a_rdata;
  logic              a_ack;

  logic              b_sel;
  logic              b_wr;
  logic [ADDR_W-1:0] b_addr;
  logic [DATA_W-1:0] b_wdata;
  logic [DATA_W-1:0] b_rdata;
  logic              b_ack;

  modport master (
    output a_sel, a_wr, a_addr, a_wdata,
    input  a_rdata, a_ack,
    output b_sel, b_wr, b_addr, b_wdata,
    input  b_rdata, b_ack
  );

  modport slave (
    input  a_sel, a_wr, a_addr, a_wdata,
    output a_rdata, a_ack,
    input  b_sel, b_wr, b_addr, b_wdata,
    output b_rdata, b_ack
  );

endinterface

// File: rtl/boreal_sram_core.sv
// Behavioural single-port SRAM: synchronous write, registered read data.
// Stands in for the on-chip macro; contents are never reset.
module boreal_sram_core #(
  parameter int DEPTH  = 1024,
  parameter int DATA_W = 32,
  parameter int AW     = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic              clk,
  input  logic              we,
  input  logic [AW-1:0]     addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[addr] <= wdata;
    rdata <= mem[addr];
  end

endmodule

// File: rtl/boreal_sram_arbiter.sv
// Round-robin responder for two Boreal word-port initiators sharing one SRAM,
// with programmable wait states, out-of-range detection and a tie counter.
module boreal_sram_arbiter
  import boreal_pkg::*;
#(
  parameter int ADDR_W      = BOREAL_SRAM_AW,
  parameter int DATA_W      = 32,
  parameter int DEPTH       = BOREAL_SRAM_DEPTH,
  parameter int WAIT_STATES = 0
) (
  input  logic                 clk,
  input  logic                 rst,
  boreal_sram_arbiter_if.slave bus,
  output logic                 busy,
  output logic                 oor_err,
  output logic [15:0]          conflict_cnt,
  output boreal_state_e        state_dbg
);

  localparam int          CORE_AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [31:0] DEPTH_U = 32'(DEPTH);

  boreal_state_e state, state_nxt;

  logic              last_grant;
  logic              gnt_port;
  logic              lat_wr;
  logic [ADDR_W-1:0] lat_addr;
  logic [DATA_W-1:0] lat_wdata;
  logic [2:0]        wait_cnt;
  logic [DATA_W-1:0] a_rdata_q;
  logic [DATA_W-1:0] b_rdata_q;
  logic [DATA_W-1:0] core_q;

  logic               pick_b;
  logic               any_req;
  logic               tie;
  logic               gnt_sel;
  logic               in_range;
  logic               grant;
  logic               commit;
  logic               wait_dec;
  logic               mem_we;
  logic [ADDR_W-1:0]  req_addr;
  logic [CORE_AW-1:0] core_addr;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= SA_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      SA_IDLE:   if (any_req) state_nxt = SA_ACCESS;
      SA_ACCESS: begin
        if (!gnt_sel)            state_nxt = SA_IDLE;
        else if (wait_cnt == '0) state_nxt = SA_ACK;
      end
      SA_ACK:    state_nxt = SA_IDLE;
      default:   state_nxt = SA_IDLE;
    endcase
  end

  always_comb begin
    pick_b   = bus.b_sel && (!bus.a_sel || last_grant == PORT_A);
    any_req  = bus.a_sel || bus.b_sel;
    tie      = bus.a_sel && bus.b_sel;
    req_addr = pick_b ? bus.b_addr : bus.a_addr;
    gnt_sel  = (gnt_port == PORT_B) ? bus.b_sel : bus.a_sel;
    // Full-width compare so addresses beyond DEPTH never alias onto the array.
    in_range = 32'(lat_addr) < DEPTH_U;
    grant    = (state == SA_IDLE) && any_req;
    commit   = (state == SA_ACCESS) && gnt_sel && (wait_cnt == '0);
    wait_dec = (state == SA_ACCESS) && gnt_sel && (wait_cnt != '0);
    mem_we   = commit && lat_wr && in_range;
    // Present the incoming address while idle so read data is already
    // registered in the core by the time the access commits.
    core_addr = CORE_AW'((state == SA_IDLE) ? req_addr : lat_addr);
    busy        = (state != SA_IDLE);
    bus.a_ack   = (state == SA_ACK) && (gnt_port == PORT_A);
    bus.b_ack   = (state == SA_ACK) && (gnt_port == PORT_B);
    bus.a_rdata = a_rdata_q;
    bus.b_rdata = b_rdata_q;
    state_dbg   = state;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_grant   <= PORT_B;
      gnt_port     <= PORT_A;
      lat_wr       <= 1'b0;
      lat_addr     <= '0;
      lat_wdata    <= '0;
      wait_cnt     <= '0;
      a_rdata_q    <= '0;
      b_rdata_q    <= '0;
      oor_err      <= 1'b0;
      conflict_cnt <= '0;
    end else begin
      if (grant) begin
        gnt_port   <= pick_b;
        last_grant <= pick_b;
        lat_wr     <= pick_b ? bus.b_wr    : bus.a_wr;
        lat_addr   <= req_addr;
        lat_wdata  <= pick_b ? bus.b_wdata : bus.a_wdata;
        wait_cnt   <= 3'(WAIT_STATES);
        if (tie && conflict_cnt != 16'hFFFF) conflict_cnt <= conflict_cnt + 16'd1;
      end
      if (wait_dec) wait_cnt <= wait_cnt - 3'd1;
      if (commit) begin
        if (!in_range) oor_err <= 1'b1;
        if (!lat_wr) begin
          if (gnt_port == PORT_A) a_rdata_q <= in_range ? core_q : '0;
          else                    b_rdata_q <= in_range ? core_q : '0;
        end
      end
    end
  end

  boreal_sram_core #(
    .DEPTH  (DEPTH),
    .DATA_W (DATA_W),
    .AW     (CORE_AW)
  ) u_core (
    .clk   (clk),
    .we    (mem_we),
    .addr  (core_addr),
    .wdata (lat_wdata),
    .rdata (core_q)
  );

endmodule

// File: tb/tb_boreal_sram_arbiter.sv
// Directed bench for boreal_sram_arbiter: three instances cover zero wait states,
// three wait states, and a 512-word array for out-of-range behaviour.
module tb_boreal_sram_arbiter;
  import boreal_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  boreal_sram_arbiter_if #(.ADDR_W(10), .DATA_W(32)) i0 ();
  boreal_sram_arbiter_if #(.ADDR_W(10), .DATA_W(32)) i3 ();
  boreal_sram_arbiter_if #(.ADDR_W(10), .DATA_W(32)) io ();

  logic busy0, busy3, busyo;
  logic oor0, oor3, ooro;
  logic [15:0] cc0, cc3, cco;
  boreal_state_e st0, st3, sto;

  boreal_sram_arbiter #(.ADDR_W(10), .DATA_W(32), .DEPTH(1024), .WAIT_STATES(0)) dut0 (
    .clk(clk), .rst(rst), .bus(i0), .busy(busy0), .oor_err(oor0), .conflict_cnt(cc0), .state_dbg(st0));
  boreal_sram_arbiter #(.ADDR_W(10), .DATA_W(32), .DEPTH(1024), .WAIT_STATES(3)) dut3 (
    .clk(clk), .rst(rst), .bus(i3), .busy(busy3), .oor_err(oor3), .conflict_cnt(cc3), .state_dbg(st3));
  boreal_sram_arbiter #(.ADDR_W(10), .DATA_W(32), .DEPTH(512), .WAIT_STATES(0)) duto (
    .clk(clk), .rst(rst), .bus(io), .busy(busyo), .oor_err(ooro), .conflict_cnt(cco), .state_dbg(sto));

  int total = 0;
  int bad   = 0;

  task automatic idle_all();
    i0.a_sel = 0; i0.a_wr = 0; i0.a_addr = '0; i0.a_wdata = '0;
    i0.b_sel = 0; i0.b_wr = 0; i0.b_addr = '0; i0.b_wdata = '0;
    i3.a_sel = 0; i3.a_wr = 0; i3.a_addr = '0; i3.a_wdata = '0;
    i3.b_sel = 0; i3.b_wr = 0; i3.b_addr = '0; i3.b_wdata = '0;
    io.a_sel = 0; io.a_wr = 0; io.a_addr = '0; io.a_wdata = '0;
    io.b_sel = 0; io.b_wr = 0; io.b_addr = '0; io.b_wdata = '0;
  endtask

  task automatic test_reset();
    @(negedge clk);
    total++;
    if ({busy0, oor0, cc0, i0.a_ack, i0.b_ack, i0.a_rdata, i0.b_rdata} !== '0) begin
      bad++; $display("FAIL reset_dut0 got busy=%0b oor=%0b cc=%0d ack=%0b%0b", busy0, oor0, cc0, i0.a_ack, i0.b_ack);
    end
    total++;
    if ({busy3, oor3, cc3, i3.a_ack, i3.b_ack, i3.a_rdata, i3.b_rdata} !== '0) begin
      bad++; $display("FAIL reset_dut3 got busy=%0b oor=%0b cc=%0d ack=%0b%0b", busy3, oor3, cc3, i3.a_ack, i3.b_ack);
    end
    total++;
    if ({busyo, ooro, cco, io.a_ack, io.b_ack, io.a_rdata, io.b_rdata} !== '0) begin
      bad++; $display("FAIL reset_duto got busy=%0b oor=%0b cc=%0d ack=%0b%0b", busyo, ooro, cco, io.a_ack, io.b_ack);
    end
    total++;
    if (st0 !== SA_IDLE) begin bad++; $display("FAIL reset_state got=%0d want=%0d", st0, SA_IDLE); end
    @(posedge clk); #1;
  endtask

  // Tie after reset: A wins, B follows; A re-requests and ties with B, so B wins.
  task automatic test_tie();
    i0.a_sel = 1; i0.a_wr = 1; i0.a_addr = 10'h010; i0.a_wdata = 32'h1111_1111;
    i0.b_sel = 1; i0.b_wr = 1; i0.b_addr = 10'h011; i0.b_wdata = 32'h2222_2222;
    for (int c = 0; c <= 8; c++) begin
      @(negedge clk);
      total++;
      if (i0.a_ack !== (c == 2 || c == 8)) begin
        bad++; $display("FAIL tie_a_ack c=%0d got=%0b want=%0b", c, i0.a_ack, (c == 2 || c == 8));
      end
      total++;
      if (i0.b_ack !== (c == 5)) begin
        bad++; $display("FAIL tie_b_ack c=%0d got=%0b want=%0b", c, i0.b_ack, (c == 5));
      end
      total++;
      if (busy0 !== !(c == 0 || c == 3 || c == 6)) begin
        bad++; $display("FAIL tie_busy c=%0d got=%0b want=%0b", c, busy0, !(c == 0 || c == 3 || c == 6));
      end
      if (c == 1) begin
        total++;
        if (cc0 !== 16'd1) begin bad++; $display("FAIL tie_cnt1 got=%0d want=1", cc0); end
      end
      if (c == 4) begin
        total++;
        if (cc0 !== 16'd2) begin bad++; $display("FAIL tie_cnt2 got=%0d want=2", cc0); end
      end
      if (c == 8) begin
        total++;
        if (i0.a_rdata !== 32'h1111_1111) begin
          bad++; $display("FAIL tie_a_rdata got=%h want=11111111", i0.a_rdata);
        end
      end
      @(posedge clk); #1;
      if (c == 2) begin i0.a_wr = 0; i0.a_addr = 10'h010; end
      if (c == 5) i0.b_sel = 0;
      if (c == 8) i0.a_sel = 0;
    end
  endtask

  task automatic test_basic();
    i0.a_sel = 1; i0.a_wr = 1; i0.a_addr = 10'h005; i0.a_wdata = 32'hCAFE_BABE;
    for (int c = 0; c <= 2; c++) begin
      @(negedge clk);
      total++;
      if (i0.a_ack !== (c == 2)) begin bad++; $display("FAIL basic_wr_ack c=%0d got=%0b want=%0b", c, i0.a_ack, (c == 2)); end
      total++;
      if (i0.b_ack !== 1'b0) begin bad++; $display("FAIL basic_wr_b_ack c=%0d got=%0b want=0", c, i0.b_ack); end
      @(posedge clk); #1;
    end
    i0.a_wr = 0;
    for (int c = 0; c <= 2; c++) begin
      @(negedge clk);
      total++;
      if (i0.a_ack !== (c == 2)) begin bad++; $display("FAIL basic_rd_ack c=%0d got=%0b want=%0b", c, i0.a_ack, (c == 2)); end
      total++;
      if (i0.b_ack !== 1'b0) begin bad++; $display("FAIL basic_rd_b_ack c=%0d got=%0b want=0", c, i0.b_ack); end
      if (c == 2) begin
        total++;
        if (i0.a_rdata !== 32'hCAFE_BABE) begin bad++; $display("FAIL basic_rd_data got=%h want=cafebabe", i0.a_rdata); end
      end
      @(posedge clk); #1;
    end
    i0.a_sel = 0;
    i0.b_sel = 1; i0.b_wr = 0; i0.b_addr = 10'h011;
    for (int c = 0; c <= 2; c++) begin
      @(negedge clk);
      total++;
      if (i0.b_ack !== (c == 2)) begin bad++; $display("FAIL basic_b_ack c=%0d got=%0b want=%0b", c, i0.b_ack, (c == 2)); end
      if (c == 2) begin
        total++;
        if (i0.b_rdata !== 32'h2222_2222) begin bad++; $display("FAIL basic_b_data got=%h want=22222222", i0.b_rdata); end
        total++;
        if (i0.a_rdata !== 32'hCAFE_BABE) begin bad++; $display("FAIL basic_a_hold got=%h want=cafebabe", i0.a_rdata); end
      end
      @(posedge clk); #1;
    end
    i0.b_sel = 0;
  endtask

  task automatic test_abort();
    i0.a_sel = 1; i0.a_wr = 1; i0.a_addr = 10'h005; i0.a_wdata = 32'hBAD0_BAD0;
    for (int c = 0; c <= 3; c++) begin
      @(negedge clk);
      total++;
      if (i0.a_ack !== 1'b0) begin bad++; $display("FAIL abort_ack c=%0d got=%0b want=0", c, i0.a_ack); end
      total++;
      if (busy0 !== (c == 1)) begin bad++; $display("FAIL abort_busy c=%0d got=%0b want=%0b", c, busy0, (c == 1)); end
      if (c == 2) begin
        total++;
        if (st0 !== SA_IDLE) begin bad++; $display("FAIL abort_state got=%0d want=%0d", st0, SA_IDLE); end
      end
      @(posedge clk); #1;
      if (c == 0) i0.a_sel = 0;
    end
    i0.a_sel = 1; i0.a_wr = 0;
    for (int c = 0; c <= 2; c++) begin
      @(negedge clk);
      if (c == 2) begin
        total++;
        if (i0.a_ack !== 1'b1) begin bad++; $display("FAIL abort_rd_ack got=%0b want=1", i0.a_ack); end
        total++;
        if (i0.a_rdata !== 32'hCAFE_BABE) begin bad++; $display("FAIL abort_rd_data got=%h want=cafebabe", i0.a_rdata); end
      end
      @(posedge clk); #1;
    end
    i0.a_sel = 0;
  endtask

  task automatic test_wait();
    i3.b_sel = 1; i3.b_wr = 1; i3.b_addr = 10'h3FF; i3.b_wdata = 32'h1234_5678;
    for (int c = 0; c <= 5; c++) begin
      @(negedge clk);
      total++;
      if (i3.b_ack !== (c == 5)) begin bad++; $display("FAIL wait_wr_ack c=%0d got=%0b want=%0b", c, i3.b_ack, (c == 5)); end
      @(posedge clk); #1;
    end
    i3.b_wr = 0;
    for (int c = 0; c <= 5; c++) begin
      @(negedge clk);
      total++;
      if (i3.b_ack !== (c == 5)) begin bad++; $display("FAIL wait_rd_ack c=%0d got=%0b want=%0b", c, i3.b_ack, (c == 5)); end
      total++;
      if (busy3 !== (c >= 1 && c <= 5)) begin
        bad++; $display("FAIL wait_busy c=%0d got=%0b want=%0b", c, busy3, (c >= 1 && c <= 5));
      end
      total++;
      if (i3.a_ack !== 1'b0) begin bad++; $display("FAIL wait_a_ack c=%0d got=%0b want=0", c, i3.a_ack); end
      if (c == 5) begin
        total++;
        if (i3.b_rdata !== 32'h1234_5678) begin bad++; $display("FAIL wait_rd_data got=%h want=12345678", i3.b_rdata); end
      end
      @(posedge clk); #1;
    end
    i3.b_sel = 0;
  endtask

  task automatic test_oor();
    logic        wr_t  [4] = '{1'b1, 1'b1, 1'b0, 1'b0};
    logic [9:0]  adr_t [4] = '{10'h000, 10'h200, 10'h200, 10'h000};
    logic [31:0] wd_t  [4] = '{32'h5A5A_5A5A, 32'hFFFF_FFFF, 32'h0, 32'h0};
    logic [31:0] rd_t  [4] = '{32'h0, 32'h0, 32'h0, 32'h5A5A_5A5A};
    logic        oor_t [4] = '{1'b0, 1'b1, 1'b1, 1'b1};
    for (int k = 0; k < 4; k++) begin
      io.a_sel = 1; io.a_wr = wr_t[k]; io.a_addr = adr_t[k]; io.a_wdata = wd_t[k];
      for (int c = 0; c <= 2; c++) begin
        @(negedge clk);
        total++;
        if (io.a_ack !== (c == 2)) begin bad++; $display("FAIL oor_ack k=%0d c=%0d got=%0b want=%0b", k, c, io.a_ack, (c == 2)); end
        if (c == 2) begin
          total++;
          if (ooro !== oor_t[k]) begin bad++; $display("FAIL oor_flag k=%0d got=%0b want=%0b", k, ooro, oor_t[k]); end
          if (!wr_t[k]) begin
            total++;
            if (io.a_rdata !== rd_t[k]) begin bad++; $display("FAIL oor_rdata k=%0d got=%h want=%h", k, io.a_rdata, rd_t[k]); end
          end
        end
        @(posedge clk); #1;
      end
    end
    io.a_sel = 0;
  endtask

  task automatic test_reset_mid();
    i3.a_sel = 1; i3.a_wr = 1; i3.a_addr = 10'h3FF; i3.a_wdata = 32'hDEAD_BEEF;
    for (int c = 0; c <= 2; c++) begin
      @(negedge clk);
      if (c == 2) begin
        total++;
        if (st3 !== SA_ACCESS) begin bad++; $display("FAIL mid_pre_state got=%0d want=%0d", st3, SA_ACCESS); end
      end
    end
    #1 rst = 1;
    #1;
    total++;
    if (i3.a_ack !== 1'b0) begin bad++; $display("FAIL mid_ack got=%0b want=0", i3.a_ack); end
    total++;
    if (busy3 !== 1'b0) begin bad++; $display("FAIL mid_busy got=%0b want=0", busy3); end
    total++;
    if (cc0 !== 16'd0) begin bad++; $display("FAIL mid_cnt got=%0d want=0", cc0); end
    @(posedge clk); #1;
    i3.a_sel = 0;
    rst = 0;
    @(posedge clk); #1;
    i3.a_sel = 1; i3.a_wr = 0; i3.a_addr = 10'h3FF;
    for (int c = 0; c <= 5; c++) begin
      @(negedge clk);
      total++;
      if (i3.a_ack !== (c == 5)) begin bad++; $display("FAIL mid_rd_ack c=%0d got=%0b want=%0b", c, i3.a_ack, (c == 5)); end
      if (c == 5) begin
        total++;
        if (i3.a_rdata !== 32'h1234_5678) begin bad++; $display("FAIL mid_rd_data got=%h want=12345678", i3.a_rdata); end
      end
      @(posedge clk); #1;
    end
    i3.a_sel = 0;
  endtask

  initial begin
    idle_all();
    repeat (3) @(posedge clk);
    #1 rst = 0;
    test_reset();
    test_tie();
    test_basic();
    test_abort();
    test_wait();
    test_oor();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

endmodule
